// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: parses single-letter commands terminated by CR from the
// UART receiver, checks them against the pet's sleep state and per-action
// cooldowns, pulses the matching action into the stats block, and queues a
// one-byte acknowledgement (K / N / E) for the UART transmitter.
//
// Optional feature macro: UART_CMD_COOLDOWN_EN
//   defined   -> feed/play/clean each get a 4-bit cooldown counter that locks
//                the action out for COOLDOWN_SECS seconds after acceptance.
//   undefined -> no cooldown hardware; feed/play/clean are refused only while
//                the pet is sleeping and COOLDOWN_SECS has no effect.
module uart_cmd_decoder #(
    parameter int unsigned COOLDOWN_SECS = 3,
    parameter int unsigned TIMEOUT_SECS  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       second,
    input  logic       is_sleeping,
    output logic       act_feed,
    output logic       act_play,
    output logic       act_clean,
    output logic       act_sleep,
    output logic       act_wake,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] err_cnt
);

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_F  = 8'h46;
    localparam logic [7:0] CHAR_P  = 8'h50;
    localparam logic [7:0] CHAR_C  = 8'h43;
    localparam logic [7:0] CHAR_S  = 8'h53;
    localparam logic [7:0] CHAR_W  = 8'h57;
    localparam logic [7:0] CHAR_K  = 8'h4B;
    localparam logic [7:0] CHAR_N  = 8'h4E;
    localparam logic [7:0] CHAR_E  = 8'h45;

    localparam logic [3:0] TMO_LIMIT = 4'(TIMEOUT_SECS);

    // Both timing parameters live in 4-bit counters, so refuse anything that
    // would not fit (or would make a zero-length window).
    if (COOLDOWN_SECS < 1 || COOLDOWN_SECS > 15) begin : gBadCooldown
        $error("uart_cmd_decoder: COOLDOWN_SECS must be within 1..15");
    end
    if (TIMEOUT_SECS < 1 || TIMEOUT_SECS > 15) begin : gBadTimeout
        $error("uart_cmd_decoder: TIMEOUT_SECS must be within 1..15");
    end

    typedef enum logic [1:0] {
        IDLE,
        GOT_CMD,
        RESPOND
    } state_t;

    state_t     state_q;
    logic [7:0] cmd_q;
    logic [3:0] tmo_q;
    logic [7:0] txData_q;
    logic       txValid_q;
    logic [7:0] errCnt_q;
    logic [7:0] errCnt_d;
    logic       actFeed_q;
    logic       actPlay_q;
    logic       actClean_q;
    logic       actSleep_q;
    logic       actWake_q;

    logic       isLetter;
    logic       isEol;
    logic       crEval;
    logic       cmdOk;
    logic       feedBusy;
    logic       playBusy;
    logic       cleanBusy;
    logic       acceptFeed;
    logic       acceptPlay;
    logic       acceptClean;

    // Classify the incoming byte and work out the saturating error count.
    always_comb begin
        isLetter = rx_data inside {CHAR_F, CHAR_P, CHAR_C, CHAR_S, CHAR_W};
        isEol    = (rx_data == CHAR_CR) || (rx_data == CHAR_LF);
        crEval   = (state_q == GOT_CMD) && rx_valid && (rx_data == CHAR_CR);
        errCnt_d = (errCnt_q == 8'hFF) ? errCnt_q : errCnt_q + 8'd1;
    end

    // Decide whether the latched command is allowed right now; sleep state is
    // taken live so it reflects the cycle in which the CR is seen.
    always_comb begin
        cmdOk = 1'b0;
        case (cmd_q)
            CHAR_F:  cmdOk = !is_sleeping && !feedBusy;
            CHAR_P:  cmdOk = !is_sleeping && !playBusy;
            CHAR_C:  cmdOk = !is_sleeping && !cleanBusy;
            CHAR_S:  cmdOk = !is_sleeping;
            CHAR_W:  cmdOk = is_sleeping;
            default: cmdOk = 1'b0;
        endcase
        acceptFeed  = crEval && cmdOk && (cmd_q == CHAR_F);
        acceptPlay  = crEval && cmdOk && (cmd_q == CHAR_P);
        acceptClean = crEval && cmdOk && (cmd_q == CHAR_C);
    end

`ifdef UART_CMD_COOLDOWN_EN
    localparam logic [3:0] CD_LOAD = 4'(COOLDOWN_SECS);

    logic [2:0] cdLoad;
    logic [3:0] cdCount_q [3];
    logic [3:0] cdCount_d [3];

    assign cdLoad = {acceptClean, acceptPlay, acceptFeed};

    // Next cooldown values: a fresh acceptance reloads and beats the tick.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cdCount_d[i] = cdCount_q[i];
            if (cdLoad[i]) begin
                cdCount_d[i] = CD_LOAD;
            end else if (second && (cdCount_q[i] != 4'd0)) begin
                cdCount_d[i] = cdCount_q[i] - 4'd1;
            end
        end
    end

    // Cooldown counter registers for feed (0), play (1) and clean (2).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) cdCount_q[i] <= 4'd0;
        end else begin
            for (int i = 0; i < 3; i++) cdCount_q[i] <= cdCount_d[i];
        end
    end

    assign feedBusy  = (cdCount_q[0] != 4'd0);
    assign playBusy  = (cdCount_q[1] != 4'd0);
    assign cleanBusy = (cdCount_q[2] != 4'd0);
`else
    assign feedBusy  = 1'b0;
    assign playBusy  = 1'b0;
    assign cleanBusy = 1'b0;
`endif

    // Frame FSM with registered action pulses, response byte and error count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cmd_q      <= 8'h00;
            tmo_q      <= 4'd0;
            txData_q   <= 8'h00;
            txValid_q  <= 1'b0;
            errCnt_q   <= 8'h00;
            actFeed_q  <= 1'b0;
            actPlay_q  <= 1'b0;
            actClean_q <= 1'b0;
            actSleep_q <= 1'b0;
            actWake_q  <= 1'b0;
        end else begin
            actFeed_q  <= 1'b0;
            actPlay_q  <= 1'b0;
            actClean_q <= 1'b0;
            actSleep_q <= 1'b0;
            actWake_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        if (isLetter) begin
                            cmd_q   <= rx_data;
                            tmo_q   <= 4'd0;
                            state_q <= GOT_CMD;
                        end else if (!isEol) begin
                            errCnt_q  <= errCnt_d;
                            txData_q  <= CHAR_E;
                            txValid_q <= 1'b1;
                            state_q   <= RESPOND;
                        end
                    end
                end
                GOT_CMD: begin
                    if (rx_valid) begin
                        if (rx_data == CHAR_CR) begin
                            actFeed_q  <= acceptFeed;
                            actPlay_q  <= acceptPlay;
                            actClean_q <= acceptClean;
                            actSleep_q <= cmdOk && (cmd_q == CHAR_S);
                            actWake_q  <= cmdOk && (cmd_q == CHAR_W);
                            txData_q   <= cmdOk ? CHAR_K : CHAR_N;
                        end else begin
                            errCnt_q <= errCnt_d;
                            txData_q <= CHAR_E;
                        end
                        txValid_q <= 1'b1;
                        state_q   <= RESPOND;
                    end else if (second) begin
                        if ((tmo_q + 4'd1) >= TMO_LIMIT) begin
                            errCnt_q  <= errCnt_d;
                            txData_q  <= CHAR_E;
                            txValid_q <= 1'b1;
                            state_q   <= RESPOND;
                        end else begin
                            tmo_q <= tmo_q + 4'd1;
                        end
                    end
                end
                RESPOND: begin
                    if (rx_valid) begin
                        errCnt_q <= errCnt_d;
                    end
                    if (tx_ready) begin
                        txValid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign act_feed  = actFeed_q;
    assign act_play  = actPlay_q;
    assign act_clean = actClean_q;
    assign act_sleep = actSleep_q;
    assign act_wake  = actWake_q;
    assign tx_data   = txData_q;
    assign tx_valid  = txValid_q;
    assign err_cnt   = errCnt_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Testbench for uart_cmd_decoder. A behavioural model tracks elapsed seconds,
// the second at which each action was last accepted, and the error count, and
// predicts every response from those.
module tb_uart_cmd_decoder;

    localparam int CD  = 3;
    localparam int TMO = 2;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] K  = 8'h4B;
    localparam logic [7:0] N  = 8'h4E;
    localparam logic [7:0] E  = 8'h45;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       second = 1'b0;
    logic       is_sleeping = 1'b0;
    logic       tx_ready = 1'b1;
    logic       act_feed, act_play, act_clean, act_sleep, act_wake;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [7:0] err_cnt;

    int total = 0;
    int bad = 0;

    int modelErr = 0;
    int secs = 0;
    int lastAccept[3];

    logic [19:0] capFrame;
    logic [7:0]  letters [5];

    logic [4:0] actVec;
    assign actVec = {act_feed, act_play, act_clean, act_sleep, act_wake};

    always #5 clk = ~clk;

    uart_cmd_decoder #(.COOLDOWN_SECS(CD), .TIMEOUT_SECS(TMO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .second(second), .is_sleeping(is_sleeping),
        .act_feed(act_feed), .act_play(act_play), .act_clean(act_clean),
        .act_sleep(act_sleep), .act_wake(act_wake),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .err_cnt(err_cnt)
    );

    // ---------------- reference model ----------------
    function automatic int actIdx(input logic [7:0] l);
        case (l)
            8'h46:   return 0;
            8'h50:   return 1;
            8'h43:   return 2;
            8'h53:   return 3;
            8'h57:   return 4;
            default: return -1;
        endcase
    endfunction

    function automatic void modelReset();
        modelErr = 0;
        for (int i = 0; i < 3; i++) lastAccept[i] = secs - 100;
    endfunction

    function automatic void modelErrInc();
        if (modelErr < 255) modelErr++;
    endfunction

    function automatic bit modelAccept(input logic [7:0] l, input bit sl);
        int idx;
        bit ok;
        idx = actIdx(l);
        ok = 1'b0;
        if (idx >= 0 && idx <= 2) begin
            ok = !sl;
`ifdef UART_CMD_COOLDOWN_EN
            if (secs - lastAccept[idx] < CD) ok = 1'b0;
`endif
            if (ok) lastAccept[idx] = secs;
        end else if (idx == 3) begin
            ok = !sl;
        end else if (idx == 4) begin
            ok = sl;
        end
        return ok;
    endfunction

    // Expected {valid@N+1, byte@N+1, acts@N+1, valid@N+2, acts@N+2} of a frame.
    function automatic logic [19:0] expFrame(input logic [7:0] l, input bit sl);
        bit ok;
        logic [4:0] a;
        ok = modelAccept(l, sl);
        a = ok ? (5'b10000 >> actIdx(l)) : 5'b00000;
        return {1'b1, ok ? K : N, a, 1'b0, 5'b00000};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic sendByte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic tick();
        second = 1'b1;
        @(negedge clk);
        second = 1'b0;
        secs++;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    task automatic applyStimulus(input logic [7:0] l, input bit sl, input int midTicks);
        is_sleeping = sl;
        sendByte(l);
        repeat (midTicks) tick();
        sendByte(CR);
        capFrame[19:6] = {tx_valid, tx_data, actVec};
        @(negedge clk);
        capFrame[5:0] = {tx_valid, actVec};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (actVec !== 5'b0) begin bad++; $display("[TB] FAIL reset_act got=%b want=00000", actVec); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h want=00", tx_data); end
        total++; if (err_cnt !== 8'h00) begin bad++; $display("[TB] FAIL reset_err got=%0d want=0", err_cnt); end
        reset = 1'b0;
        modelReset();
    endtask

    task automatic test_feed();
        logic [19:0] exp;
        applyStimulus(8'h46, 1'b0, 0);
        exp = expFrame(8'h46, 1'b0);
        total++; if (capFrame !== exp) begin bad++; $display("[TB] FAIL feed_frame got=%h want=%h", capFrame, exp); end
        total++; if (err_cnt !== 8'(modelErr)) begin bad++; $display("[TB] FAIL feed_err got=%0d want=%0d", err_cnt, modelErr); end
    endtask

    task automatic test_cooldown();
        logic [19:0] exp;
        applyReset();
        applyStimulus(8'h46, 1'b0, 0);
        exp = expFrame(8'h46, 1'b0);
        total++; if (capFrame !== exp) begin bad++; $display("[TB] FAIL cd_first got=%h want=%h", capFrame, exp); end
        repeat (CD - 1) tick();
        applyStimulus(8'h46, 1'b0, 0);
        exp = expFrame(8'h46, 1'b0);
        total++; if (capFrame !== exp) begin bad++; $display("[TB] FAIL cd_locked got=%h want=%h", capFrame, exp); end
        tick();
        applyStimulus(8'h46, 1'b0, 0);
        exp = expFrame(8'h46, 1'b0);
        total++; if (capFrame !== exp) begin bad++; $display("[TB] FAIL cd_expired got=%h want=%h", capFrame, exp); end
    endtask

    task automatic test_sleep_wake();
        logic [19:0] exp;
        logic [7:0] l [5];
        bit sl [5];
        l = '{8'h53, 8'h57, 8'h53, 8'h57, 8'h50};
        sl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(l[i], sl[i], 0);
            exp = expFrame(l[i], sl[i]);
            total++; if (capFrame !== exp) begin bad++; $display("[TB] FAIL sleep_wake_%0d got=%h want=%h", i, capFrame, exp); end
        end
    endtask

    task automatic test_bad_second_byte();
        is_sleeping = 1'b0;
        sendByte(8'h50);
        sendByte(8'h58);
        modelErrInc();
        total++; if ({tx_valid, tx_data, actVec} !== {1'b1, E, 5'b0}) begin bad++; $display("[TB] FAIL bad_byte_resp got=%b/%h/%b want=1/45/00000", tx_valid, tx_data, actVec); end
        total++; if (err_cnt !== 8'(modelErr)) begin bad++; $display("[TB] FAIL bad_byte_err got=%0d want=%0d", err_cnt, modelErr); end
        @(negedge clk);
        total++; if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL bad_byte_hs got=%b want=0", tx_valid); end
    endtask

    task automatic test_timeout();
        sendByte(8'h43);
        repeat (TMO - 1) tick();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL timeout_early got=%b want=0", tx_valid); end
        tick();
        modelErrInc();
        total++; if ({tx_valid, tx_data, actVec} !== {1'b1, E, 5'b0}) begin bad++; $display("[TB] FAIL timeout_resp got=%b/%h/%b want=1/45/00000", tx_valid, tx_data, actVec); end
        total++; if (err_cnt !== 8'(modelErr)) begin bad++; $display("[TB] FAIL timeout_err got=%0d want=%0d", err_cnt, modelErr); end
        @(negedge clk);
    endtask

    task automatic test_cr_vs_second();
        bit ok;
        is_sleeping = 1'b1;
        sendByte(8'h57);
        repeat (TMO - 1) tick();
        rx_data = CR;
        rx_valid = 1'b1;
        second = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        second = 1'b0;
        secs++;
        ok = modelAccept(8'h57, 1'b1);
        total++; if ({tx_valid, tx_data, actVec} !== {1'b1, ok ? K : N, ok ? 5'b00001 : 5'b0}) begin bad++; $display("[TB] FAIL cr_vs_second got=%b/%h/%b want=1/%h", tx_valid, tx_data, actVec, ok ? K : N); end
        total++; if (err_cnt !== 8'(modelErr)) begin bad++; $display("[TB] FAIL cr_vs_second_err got=%0d want=%0d", err_cnt, modelErr); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [19:0] exp;
        exp = expFrame(8'h53, 1'b0);
        tx_ready = 1'b0;
        is_sleeping = 1'b0;
        sendByte(8'h53);
        sendByte(CR);
        total++; if ({tx_valid, tx_data, actVec} !== exp[19:6]) begin bad++; $display("[TB] FAIL bp_first got=%b/%h/%b want=%h", tx_valid, tx_data, actVec, exp[19:6]); end
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                sendByte(8'($urandom_range(0, 255)));
                modelErrInc();
            end else begin
                @(negedge clk);
            end
            total++; if ({tx_valid, tx_data, actVec} !== {1'b1, exp[18:11], 5'b0}) begin bad++; $display("[TB] FAIL bp_hold_%0d got=%b/%h/%b want=1/%h/00000", i, tx_valid, tx_data, actVec, exp[18:11]); end
        end
        total++; if (err_cnt !== 8'(modelErr)) begin bad++; $display("[TB] FAIL bp_err got=%0d want=%0d", err_cnt, modelErr); end
        tx_ready = 1'b1;
        @(negedge clk);
        total++; if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release got=%b want=0", tx_valid); end
    endtask

    task automatic test_idle_bytes();
        logic [7:0] b;
        sendByte(CR);
        sendByte(LF);
        total++; if ({tx_valid, err_cnt} !== {1'b0, 8'(modelErr)}) begin bad++; $display("[TB] FAIL eol_ignored got=%b/%0d want=0/%0d", tx_valid, err_cnt, modelErr); end
        for (int i = 0; i < 4; i++) begin
            do b = 8'($urandom_range(0, 255)); while (actIdx(b) >= 0 || b == CR || b == LF);
            sendByte(b);
            modelErrInc();
            total++; if ({tx_valid, tx_data, err_cnt} !== {1'b1, E, 8'(modelErr)}) begin bad++; $display("[TB] FAIL idle_junk_%0d byte=%h got=%b/%h/%0d want=1/45/%0d", i, b, tx_valid, tx_data, err_cnt, modelErr); end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [19:0] exp;
        logic [7:0] l;
        bit sl;
        for (int i = 0; i < 40; i++) begin
            l = letters[$urandom_range(0, 4)];
            sl = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) tick();
            applyStimulus(l, sl, $urandom_range(0, TMO - 1));
            exp = expFrame(l, sl);
            total++; if (capFrame !== exp) begin bad++; $display("[TB] FAIL rand_%0d cmd=%h sleep=%b got=%h want=%h", i, l, sl, capFrame, exp); end
        end
        total++; if (err_cnt !== 8'(modelErr)) begin bad++; $display("[TB] FAIL rand_err got=%0d want=%0d", err_cnt, modelErr); end
    endtask

    task automatic test_saturate();
        repeat (300) begin
            sendByte(8'h58);
            modelErrInc();
            @(negedge clk);
        end
        total++; if (err_cnt !== 8'(modelErr) || modelErr != 255) begin bad++; $display("[TB] FAIL saturate got=%0d want=255", err_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [19:0] exp;
        is_sleeping = 1'b0;
        sendByte(8'h46);
        reset = 1'b1;
        sendByte(CR);
        reset = 1'b0;
        modelReset();
        total++; if ({actVec, tx_valid, tx_data, err_cnt} !== 22'h0) begin bad++; $display("[TB] FAIL reset_frame got=%b/%b/%h/%0d want=0", actVec, tx_valid, tx_data, err_cnt); end
        tx_ready = 1'b0;
        sendByte(8'h51);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tx_ready = 1'b1;
        modelReset();
        total++; if ({actVec, tx_valid, tx_data, err_cnt} !== 22'h0) begin bad++; $display("[TB] FAIL reset_respond got=%b/%b/%h/%0d want=0", actVec, tx_valid, tx_data, err_cnt); end
        applyStimulus(8'h46, 1'b0, 0);
        exp = expFrame(8'h46, 1'b0);
        total++; if (capFrame !== exp) begin bad++; $display("[TB] FAIL reset_after got=%h want=%h", capFrame, exp); end
    endtask

    initial begin
        letters = '{8'h46, 8'h50, 8'h43, 8'h53, 8'h57};
        test_reset();
        test_feed();
        test_cooldown();
        test_sleep_wake();
        test_bad_second_byte();
        test_timeout();
        test_cr_vs_second();
        test_backpressure();
        test_idle_bytes();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Command decoder between the UART receiver and the `stats` block. Takes received bytes, parses single-letter commands terminated by CR, checks each against the pet's sleep state and a per-action cooldown, and issues one-cycle action pulses to `stats`. Every frame gets a one-byte acknowledgement for the UART transmitter, using a valid/ready handshake.

## Interface
- `COOLDOWN_SECS`, default 3: seconds a feed/play/clean action is locked out after it is accepted (1–15).
- `TIMEOUT_SECS`, default 2: `second` ticks allowed between a command letter and its CR (1–15).

- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte; valid only while `rx_valid` is high.
- `rx_valid`  in  1  one-cycle strobe marking a new received byte.
- `second`  in  1  one-cycle tick, once per second.
- `is_sleeping`  in  1  current sleep state from `stats`.
- `act_feed`, `act_play`, `act_clean`, `act_sleep`, `act_wake`  out  1 each  one-cycle action pulses to `stats`.
- `tx_data`  out  8  response byte.
- `tx_valid`  out  1  response is pending.
- `tx_ready`  in  1  transmitter accepts the byte when `tx_valid` and `tx_ready` are both high.
- `err_cnt`  out  8  count of protocol errors; saturates at 255.

## Operation
- Command letters (uppercase ASCII only): `F`=0x46 feed, `P`=0x50 play, `C`=0x43 clean, `S`=0x53 sleep, `W`=0x57 wake.
- Frame format: one letter, then CR (0x0D).
- The FSM has three states:
  - **IDLE**
    - Letter byte: latch the command, clear the timeout counter, go to GOT_CMD.
    - CR (0x0D) or LF (0x0A): ignored.
    - Any other byte: increment `err_cnt`, load `E` (0x45), go to RESPOND.
  - **GOT_CMD**
    - CR: evaluate the latched command, then go to RESPOND.
      - Accepted: pulse the matching `act_*` and load `K` (0x4B).
      - Rejected: no pulse; load `N` (0x4E).
    - Any other byte, including a second letter: increment `err_cnt`, load `E`, go to RESPOND.
    - Timeout counter reaches `TIMEOUT_SECS` (incremented on `second`): increment `err_cnt`, load `E`, go to RESPOND.
  - **RESPOND**
    - `tx_valid` is held high with `tx_data` stable until the handshake completes, then the FSM returns to IDLE.
    - Any `rx_valid` byte here is dropped and increments `err_cnt`.
- Acceptance rules:
  - F, P and C are rejected while `is_sleeping` = 1 or while that action's cooldown is nonzero.
  - S is rejected if already sleeping.
  - W is rejected if not sleeping.
- Cooldown: F, P and C each have an independent 4-bit counter.
  - Loaded with `COOLDOWN_SECS` when the action is accepted.
  - Decremented on each `second` while nonzero.
  - Loading wins over decrementing in the same cycle.
- `err_cnt`: saturating increment; holds at 255.
- `is_sleeping` is sampled in the cycle the CR arrives.

## Timing
- Reset values:
  - State IDLE.
  - All `act_*` = 0, `tx_valid` = 0, `tx_data` = 0x00, `err_cnt` = 0.
  - All cooldown and timeout counters = 0.
- Latency: CR sampled at cycle N → `act_*` high and `tx_valid` high at cycle N+1, both registered. `act_*` is high for exactly one cycle.
- Handshake: if `tx_ready` is high at cycle N+1, `tx_valid` drops at N+2 and the FSM is in IDLE at N+2. A byte arriving at N+2 is accepted.
- Sustained `tx_ready` = 0 holds RESPOND indefinitely; the timeout does not apply in RESPOND.
- `second` coinciding with the CR: the CR wins and the frame is evaluated, not timed out.
- `reset` asserted mid-frame or mid-RESPOND: next cycle is the reset state, the pending response is discarded, and no action pulse is issued.

## Configuration
- `UART_CMD_COOLDOWN_EN` defined: cooldown counters are built and enforced as described above.
- `UART_CMD_COOLDOWN_EN` undefined: no cooldown logic is built. F, P and C are rejected only while sleeping, and `COOLDOWN_SECS` is ignored.

## Test plan
- After reset, send `F`, CR with `is_sleeping` = 0 → one `act_feed` pulse, `tx_data` = 0x4B, `err_cnt` = 0.
- Macro defined, `COOLDOWN_SECS` = 3:
  - `F`, CR, then `F`, CR after 2 ticks → second response 0x4E, no pulse.
  - After a 3rd tick, `F`, CR → 0x4B plus a pulse.
- `S`, CR with `is_sleeping` = 1 → 0x4E, no `act_sleep`.
- `W`, CR with `is_sleeping` = 1 → `act_wake` pulse, 0x4B.
- `P` followed by `X` → 0x45, `err_cnt` = 1.
- `C` followed by 2 `second` ticks → 0x45, `err_cnt` = 1.
- Hold `tx_ready` = 0 for 10 cycles during RESPOND while sending a byte:
  - `tx_valid` stays high and `tx_data` stays stable.
  - `err_cnt` increments by 1.
  - Handshake completes on `tx_ready` = 1.
- Force 300 errors → `err_cnt` = 255.
- Reset pulse mid-frame → all outputs read 0 the next cycle.
